// File: rtl/bit_scan_counter_if.sv
// Bus bundle for the bit scan engine: start level, mode and operand in,
// busy/done/result out.
//
// Handshake: a level handshake. The master raises s to request a scan. The
// engine samples A and mode on the edge where it leaves IDLE and ignores
// them from then on. busy is high while the scan runs. done is high once
// result is valid, and done and result stay stable for as long as s stays
// high. The master acknowledges by dropping s. The engine returns to IDLE on
// the first edge that sees s low. A new scan needs s low for at least one
// edge first.
interface bit_scan_counter_if #(
    parameter int A_WIDTH   = 8,
    parameter int RES_WIDTH = $clog2(A_WIDTH + 1)
);
    logic                 s;
    logic [1:0]           mode;
    logic [A_WIDTH-1:0]   A;
    logic                 busy;
    logic                 done;
    logic [RES_WIDTH-1:0] result;

    modport master (output s, output mode, output A,
                    input  busy, input done, input result);
    modport slave  (input  s, input mode, input A,
                    output busy, output done, output result);
endinterface

// File: rtl/bit_scan_counter.sv
// Serial bit scan engine. It consumes BPC operand bits per clock and
// supports four modes: popcount of ones, popcount of zeros, trailing-zero
// count and leading-zero count. A scan may stop early, so its latency
// depends on the operand data.
module bit_scan_counter #(
    parameter int A_WIDTH   = 8,
    parameter int BPC       = 1,
    parameter int RES_WIDTH = $clog2(A_WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    bit_scan_counter_if.slave   bus,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(A_WIDTH + 1);

    if (A_WIDTH < 2 || BPC < 1 || (A_WIDTH % BPC) != 0) begin : g_bad_params
        $error("bit_scan_counter: need A_WIDTH >= 2, BPC >= 1, and BPC must divide A_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [A_WIDTH-1:0]   r;
    logic [1:0]           mode_q;
    logic [RES_WIDTH-1:0] result_q;
    logic [CNT_W-1:0]     consumed;

    logic [BPC-1:0]       chunk;
    logic [BPC-1:0]       chunk_ord;   // bit 0 is the first bit in scan order
    logic [RES_WIDTH-1:0] pop;
    logic [RES_WIDTH-1:0] lead_zeros;
    logic                 found;
    logic [RES_WIDTH-1:0] contrib;
    logic [A_WIDTH-1:0]   r_next;
    logic [CNT_W-1:0]     consumed_next;
    logic                 finish;

    // Slice out this cycle's chunk, score it for the active mode, and decide whether the scan ends.
    always_comb begin
        chunk         = '0;
        chunk_ord     = '0;
        pop           = '0;
        lead_zeros    = '0;
        found         = 1'b0;
        contrib       = '0;
        r_next        = r;
        consumed_next = consumed + CNT_W'(BPC);
        finish        = 1'b0;

        // Leading-zero mode walks the operand from the top, so it takes the
        // high chunk, reverses it into scan order, and shifts left.
        if (mode_q == 2'd3) begin
            chunk  = r[A_WIDTH-1 -: BPC];
            r_next = r << BPC;
        end else begin
            chunk  = r[BPC-1:0];
            r_next = r >> BPC;
        end

        for (int i = 0; i < BPC; i++) begin
            chunk_ord[i] = (mode_q == 2'd3) ? chunk[BPC-1-i] : chunk[i];
        end

        for (int i = 0; i < BPC; i++) begin
            pop = pop + RES_WIDTH'(chunk[i]);
        end

        // Count the zeros ahead of the first 1. An all-zero chunk counts BPC.
        for (int i = 0; i < BPC; i++) begin
            if (!found) begin
                if (chunk_ord[i]) found = 1'b1;
                else              lead_zeros = lead_zeros + 1'b1;
            end
        end

        case (mode_q)
            2'd0:    contrib = pop;
            2'd1:    contrib = RES_WIDTH'(BPC) - pop;
            default: contrib = lead_zeros;
        endcase

        // Ones mode can stop once nothing is left to count. The zero-scan
        // modes stop on the chunk that holds the first 1.
        finish = (consumed_next == CNT_W'(A_WIDTH))
               || ((mode_q == 2'd0) && (r_next == '0))
               || (mode_q[1] && found);
    end

    // Next-state logic. The scan runs to its own end, and DONE waits for s to drop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.s)  state_next = RUN;
            RUN:     if (finish) state_next = DONE;
            DONE:    if (!bus.s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus datapath: capture on start, accumulate while running, freeze otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            r        <= '0;
            mode_q   <= 2'd0;
            result_q <= '0;
            consumed <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.s) begin
                        r        <= bus.A;
                        mode_q   <= bus.mode;
                        result_q <= '0;
                        consumed <= '0;
                    end
                end
                RUN: begin
                    r        <= r_next;
                    consumed <= consumed_next;
                    result_q <= result_q + contrib;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_bit_scan_counter.sv
// Bench for bit_scan_counter. It runs three builds in lock-step from the same
// stimulus (BPC = 2, 1 and 8, all with A_WIDTH = 8). A behavioural model
// predicts each scan's result and RUN-cycle count, and per-build monitors
// compare against those predictions when done rises.
module tb_bit_scan_counter;

    localparam int AW = 8;
    localparam int RW = $clog2(AW + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          s;
    logic [1:0]    mode;
    logic [AW-1:0] a;
    logic [1:0]    dbg2, dbg1, dbg8;

    int n_checks = 0;
    int n_errors = 0;

    // Entry layout: {expected RUN cycles[15:8], expected result[7:0]}
    logic [15:0] exp_q2[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_q8[$];

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    bit_scan_counter_if #(.A_WIDTH(AW)) bus2 ();
    bit_scan_counter_if #(.A_WIDTH(AW)) bus1 ();
    bit_scan_counter_if #(.A_WIDTH(AW)) bus8 ();

    assign bus2.s = s;  assign bus2.mode = mode;  assign bus2.A = a;
    assign bus1.s = s;  assign bus1.mode = mode;  assign bus1.A = a;
    assign bus8.s = s;  assign bus8.mode = mode;  assign bus8.A = a;

    bit_scan_counter #(.A_WIDTH(AW), .BPC(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .dbg_state(dbg2));
    bit_scan_counter #(.A_WIDTH(AW), .BPC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1), .dbg_state(dbg1));
    bit_scan_counter #(.A_WIDTH(AW), .BPC(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8), .dbg_state(dbg8));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_result(input logic [1:0] m, input logic [AW-1:0] v);
        int  ones = 0;
        int  tz   = 0;
        int  lz   = 0;
        bit  f;
        for (int i = 0; i < AW; i++) ones += int'(v[i]);
        f = 1'b0;
        for (int i = 0; i < AW; i++)
            if (!f) begin if (v[i]) f = 1'b1; else tz++; end
        f = 1'b0;
        for (int i = AW - 1; i >= 0; i--)
            if (!f) begin if (v[i]) f = 1'b1; else lz++; end
        case (m)
            2'd0:    return ones;
            2'd1:    return AW - ones;
            2'd2:    return tz;
            default: return lz;
        endcase
    endfunction

    function automatic int model_cycles(input logic [1:0] m, input logic [AW-1:0] v, input int bpc);
        int msb = 0;
        for (int i = 0; i < AW; i++) if (v[i]) msb = i;
        case (m)
            2'd0:    return (v == '0) ? 1 : (msb + bpc) / bpc;
            2'd1:    return AW / bpc;
            default: return (v == '0) ? AW / bpc : model_result(m, v) / bpc + 1;
        endcase
    endfunction

    // ---------------- monitors (sample on negedge) ----------------
    int   run2 = 0, run1 = 0, run8 = 0;
    logic done2_d = 1'b0, done1_d = 1'b0, done8_d = 1'b0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            run2 <= 0; done2_d <= 1'b0;
        end else begin
            if (bus2.busy) run2 <= run2 + 1;
            if (bus2.done && !done2_d) begin
                if (exp_q2.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL bpc2_unexpected_done: got done=1 required no pending scan");
                end else begin
                    e = exp_q2.pop_front();
                    chk("bpc2_result", 32'(bus2.result), 32'(e[7:0]));
                    chk("bpc2_cycles", 32'(run2), 32'(e[15:8]));
                end
                run2 <= 0;
            end
            done2_d <= bus2.done;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            run1 <= 0; done1_d <= 1'b0;
        end else begin
            if (bus1.busy) run1 <= run1 + 1;
            if (bus1.done && !done1_d) begin
                if (exp_q1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL bpc1_unexpected_done: got done=1 required no pending scan");
                end else begin
                    e = exp_q1.pop_front();
                    chk("bpc1_result", 32'(bus1.result), 32'(e[7:0]));
                    chk("bpc1_cycles", 32'(run1), 32'(e[15:8]));
                end
                run1 <= 0;
            end
            done1_d <= bus1.done;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            run8 <= 0; done8_d <= 1'b0;
        end else begin
            if (bus8.busy) run8 <= run8 + 1;
            if (bus8.done && !done8_d) begin
                if (exp_q8.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL bpc8_unexpected_done: got done=1 required no pending scan");
                end else begin
                    e = exp_q8.pop_front();
                    chk("bpc8_result", 32'(bus8.result), 32'(e[7:0]));
                    chk("bpc8_cycles", 32'(run8), 32'(e[15:8]));
                end
                run8 <= 0;
            end
            done8_d <= bus8.done;
        end
    end

    // ---------------- driver ----------------
    task automatic run_scan(input logic [1:0] m, input logic [AW-1:0] v,
                            input bit scramble, input int hold);
        int  res;
        bit  all_done;
        res = model_result(m, v);
        exp_q2.push_back({8'(model_cycles(m, v, 2)), 8'(res)});
        exp_q1.push_back({8'(model_cycles(m, v, 1)), 8'(res)});
        exp_q8.push_back({8'(model_cycles(m, v, 8)), 8'(res)});
        mode = m; a = v; s = 1'b1;
        all_done = 1'b0;
        for (int cyc = 0; cyc < 40 && !all_done; cyc++) begin
            @(posedge clk); #1;
            if (scramble) begin a = AW'($urandom); mode = 2'($urandom_range(0, 3)); end
            all_done = bus2.done && bus1.done && bus8.done;
        end
        if (!all_done) begin
            n_checks++; n_errors++;
            $display("FAIL scan_timeout: got no done within 40 cycles required done (mode %0d A %0h)", m, v);
        end
        // With s still high, DONE must hold and result must stay frozen.
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (scramble) begin a = AW'($urandom); mode = 2'($urandom_range(0, 3)); end
            chk("hold_done", 32'(bus2.done), 32'd1);
            chk("hold_result", 32'(bus2.result), 32'(res));
            chk("hold_result_bpc1", 32'(bus1.result), 32'(res));
        end
        s = 1'b0;
        @(posedge clk); #1;
        chk("ack_done2", 32'(bus2.done), 32'd0);
        chk("ack_done1", 32'(bus1.done), 32'd0);
        chk("ack_done8", 32'(bus8.done), 32'd0);
        chk("ack_busy2", 32'(bus2.busy), 32'd0);
        chk("ack_state2", 32'(dbg2), 32'd0);
        chk("idle_result_held", 32'(bus2.result), 32'(res));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; s = 1'b0; mode = 2'd0; a = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(dbg2), 32'd0);
        chk("reset_result", 32'(bus2.result), 32'd0);
        chk("reset_done", 32'(bus2.done), 32'd0);
        chk("reset_busy", 32'(bus2.busy), 32'd0);
        reset = 1'b0;
        a = 8'hAA;

        // With s low, the engine stays idle and ignores A.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_done", 32'(bus2.done), 32'd0);
            chk("idle_busy", 32'(bus2.busy), 32'd0);
            chk("idle_result", 32'(bus2.result), 32'd0);
        end

        // Directed scans from the plan.
        run_scan(2'd0, 8'b1010_1010, 1'b0, 1);
        run_scan(2'd0, 8'b0000_0011, 1'b0, 0);
        run_scan(2'd0, 8'h00,        1'b0, 0);
        run_scan(2'd1, 8'b1111_0000, 1'b0, 1);
        run_scan(2'd2, 8'b0010_1000, 1'b0, 0);
        run_scan(2'd3, 8'b0001_0000, 1'b0, 0);
        run_scan(2'd3, 8'h00,        1'b0, 1);
        run_scan(2'd2, 8'h00,        1'b0, 0);
        run_scan(2'd2, 8'h80,        1'b0, 0);
        run_scan(2'd3, 8'h01,        1'b0, 0);
        run_scan(2'd0, 8'h80,        1'b0, 0);

        // Inputs churn during RUN and DONE while s is held high.
        run_scan(2'd0, 8'h96, 1'b1, 5);
        run_scan(2'd2, 8'h40, 1'b1, 3);

        // Reset lands in the second RUN cycle of a mode 1 scan.
        mode = 2'd1; a = 8'hF0; s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(bus2.busy), 32'd1);
        reset = 1'b1; s = 1'b0;
        @(posedge clk); #1;
        chk("abort_state", 32'(dbg2), 32'd0);
        chk("abort_result", 32'(bus2.result), 32'd0);
        chk("abort_busy", 32'(bus2.busy), 32'd0);
        chk("abort_done", 32'(bus2.done), 32'd0);
        chk("abort_result_bpc1", 32'(bus1.result), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_scan(2'd0, 8'hFF, 1'b0, 0);

        // Random scans.
        for (int i = 0; i < 25; i++) begin
            run_scan(2'($urandom_range(0, 3)), AW'($urandom), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q2_drained", 32'(exp_q2.size()), 32'd0);
        chk("q1_drained", 32'(exp_q1.size()), 32'd0);
        chk("q8_drained", 32'(exp_q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
